instr_fetch_unit: RTL and testbench

Instruction fetch front end of the RV32I core. It issues in-order word fetches to instruction memory and buffers the returned words in a small FIFO. It delivers them with their PC to the decode stage over a valid/ready handshake, already split into `opcode`/`funct3`/`funct7` for `control_unit`. Branch and jump redirects flush the buffer and discard responses still in flight for the old stream.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/instr_fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants, fetch-stage types and helpers.
//   NOP_INSTR        canonical NOP (addi x0, x0, 0)
//   *_LSB / *_W      instruction field positions used by decode-side slicing
//   fetch_state_t    fetch FSM states
//   fetch_entry_t    buffered fetch word with its PC
//   wrap_inc         circular-pointer increment for non power-of-two depths
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_W   = 7;

    typedef enum logic {
        FS_BOOT,
        FS_RUN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic int wrap_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// instr_fetch_fifo: synchronous FIFO of {pc, word} fetch entries.
//   clk, rst     clock, synchronous active-high reset
//   push         write push_entry at the tail
//   pop          drop the head entry
//   flush        empty the FIFO (wins over push/pop)
//   count        occupancy, 0..DEPTH
//   head         oldest entry; valid when count != 0
module instr_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk)
        if (push && !flush)
            mem[wr_ptr] <= push_entry;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= PW'(wrap_inc(int'(wr_ptr), DEPTH));
            if (pop)
                rd_ptr <= PW'(wrap_inc(int'(rd_ptr), DEPTH));
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // The request limit upstream guarantees a push never meets a full FIFO.
    always_ff @(posedge clk)
        if (!rst && !flush && push && !pop)
            assert (count != CW'(DEPTH));

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch front end with redirect and response dropping.
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  in-order word fetch requests
//   imem_rsp_valid, imem_rdata       in-order responses, never back-pressured
//   redirect_valid, redirect_pc      taken branch/jump: flush and refetch
//   instr_valid/ready, instr, instr_pc  decode handshake (NOP/0 when idle)
//   opcode, funct3, funct7           field slices of instr
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = $clog2(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_n;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [CW:0]   live;
    logic          accept;
    logic          redir;
    logic          push;
    logic          pop;
    logic [31:0]   pcq [DEPTH];
    logic [PW-1:0] pcq_rd;
    logic [PW-1:0] pcq_wr;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    always_ff @(posedge clk)
        state <= rst ? FS_BOOT : state_n;

    always_comb
        state_n = (state == FS_BOOT) ? FS_RUN : state;

    // Requests are limited by live words (in flight and not to be dropped,
    // plus buffered). Raw in-flight is also capped so the counters never wrap
    // while dropped responses are still on their way back.
    always_comb begin
        live           = CW1'(outstanding) + CW1'(count) - CW1'(drop_cnt);
        imem_req_valid = (state == FS_RUN) && (live < CW1'(DEPTH)) && (outstanding < CW'(DEPTH));
        instr_valid    = (count != '0);
        instr          = instr_valid ? head.word : NOP_INSTR;
        instr_pc       = instr_valid ? head.pc : 32'h0;
        opcode         = instr[OPCODE_LSB +: OPCODE_W];
        funct3         = instr[FUNCT3_LSB +: FUNCT3_W];
        funct7         = instr[FUNCT7_LSB +: FUNCT7_W];
    end

    assign imem_addr     = fetch_pc;
    assign accept        = imem_req_valid && imem_req_ready;
    assign redir         = redirect_valid && (state == FS_RUN);
    assign push          = imem_rsp_valid && (drop_cnt == '0) && !redir;
    assign pop           = instr_valid && instr_ready;
    assign outstanding_n = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    assign push_entry    = '{pc: pcq[pcq_rd], word: imem_rdata};

    // On redirect every response still due (including one accepted this
    // cycle) belongs to the old stream; a response arriving now is dropped too.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC & ~32'd3;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            fetch_pc    <= redirect_valid ? (redirect_pc & ~32'd3) : fetch_pc + (accept ? 32'd4 : 32'd0);
            outstanding <= outstanding_n;
            drop_cnt    <= redir ? outstanding_n : drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
            pcq_rd      <= redir ? '0 : push ? PW'(wrap_inc(int'(pcq_rd), DEPTH)) : pcq_rd;
            pcq_wr      <= redir ? '0 : accept ? PW'(wrap_inc(int'(pcq_wr), DEPTH)) : pcq_wr;
        end
    end

    // PC queue holds addresses of live (non-dropped) requests in order.
    always_ff @(posedge clk)
        if (accept && !redir)
            pcq[pcq_wr] <= fetch_pc;

    instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redir),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with memory model and delivery scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 0;
    logic        rst = 1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rdata = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        instr_valid;
    logic        instr_ready = 1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic        w_req_valid;
    logic [31:0] w_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int cyc = 0;
    int acc_cnt = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mq [$];
    logic [31:0] exp_q [$];
    logic [31:0] e;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_addr      (w_addr),
        .imem_rsp_valid (1'b0),
        .imem_rdata     (32'h0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (w_instr_valid),
        .instr_ready    (1'b1),
        .instr          (w_instr),
        .instr_pc       (w_instr_pc),
        .opcode         (w_opcode),
        .funct3         (w_funct3),
        .funct7         (w_funct7)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_addr"}, imem_addr, 32'h100);
        chk({tag, "_instr_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 32'h13);
        chk({tag, "_instr_pc"}, instr_pc, 0);
        chk({tag, "_opcode"}, opcode, 7'h13);
        chk({tag, "_funct3"}, funct3, 0);
        chk({tag, "_funct7"}, funct7, 0);
    endtask

    // Memory model (fixed latency, in order) and delivery scoreboard.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() != 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1;
            imem_rdata     = mq[0].addr + 32'h1000;
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 0;
            imem_rdata     = 32'h0;
        end
        #7;
        if (rst) begin
            mq.delete();
            exp_q.delete();
        end else begin
            if (instr_valid && instr_ready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected: got pc %h expected no delivery", instr_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e);
                    chk("sb_word", instr, e + 32'h1000);
                    chk("sb_opcode", opcode, {25'h0, instr[6:0]});
                end
            end
            if (redirect_valid)
                exp_q.delete();
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                mq.push_back('{cyc + lat, imem_addr});
                if (!redirect_valid)
                    exp_q.push_back(imem_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        logic [31:0] w;

        // Reset state, boot cycle, 1-cycle memory streaming, wrap instance.
        step();
        step();
        chk_reset_outputs("rst");
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        rst = 0;
        chk("boot_no_req", imem_req_valid, 0);
        chk("wrap_boot_no_req", w_req_valid, 0);
        step();
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_addr, 32'h100);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        step();
        chk("second_req_addr", imem_addr, 32'h104);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr2", w_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            w = 32'h1100 + 32'(4 * i);
            chk("stream_valid", instr_valid, 1);
            chk("stream_pc", instr_pc, 32'h100 + 32'(4 * i));
            chk("stream_instr", instr, w);
            chk("stream_funct3", funct3, {29'h0, w[14:12]});
            step();
        end

        // Back-pressure: fill exactly DEPTH, then drain in order and resume.
        rst = 1;
        instr_ready = 0;
        step();
        step();
        rst = 0;
        acc_cnt = 0;
        repeat (11) step();
        chk("full_acc_cnt", acc_cnt, 4);
        chk("full_no_req", imem_req_valid, 0);
        chk("full_valid", instr_valid, 1);
        instr_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", instr_pc, 32'h100 + 32'(4 * i));
            chk("drain_instr", instr, 32'h1100 + 32'(4 * i));
            if (i == 0)
                chk("drain_pop_cycle_no_req", imem_req_valid, 0);
            if (i == 1) begin
                chk("resume_req", imem_req_valid, 1);
                chk("resume_addr", imem_addr, 32'h110);
            end
            step();
        end

        // Redirect with two responses in flight on a 3-cycle memory.
        rst = 1;
        lat = 3;
        step();
        step();
        rst = 0;
        step();
        step();
        step();
        imem_req_ready = 0;
        redirect_valid = 1;
        redirect_pc = 32'h203;
        step();
        redirect_valid = 0;
        imem_req_ready = 1;
        chk("redir_req_valid", imem_req_valid, 1);
        chk("redir_req_addr", imem_addr, 32'h200);
        for (int k = 0; k < 20 && !instr_valid; k++)
            step();
        chk("redir_first_valid", instr_valid, 1);
        chk("redir_first_pc", instr_pc, 32'h200);
        chk("redir_first_instr", instr, 32'h1200);

        // Redirect together with an arriving response and a decode handshake.
        rst = 1;
        lat = 1;
        step();
        step();
        rst = 0;
        repeat (6) step();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #2;
            found = imem_rsp_valid && instr_valid;
        end
        chk("same_cycle_aligned", found, 1);
        redirect_valid = 1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 0;
        chk("same_cycle_empty_next", instr_valid, 0);
        chk("same_cycle_req_addr", imem_addr, 32'h300);
        for (int k = 0; k < 10 && !instr_valid; k++)
            step();
        chk("same_cycle_first_pc", instr_pc, 32'h300);

        // Reset in the middle of a stream with a full FIFO.
        instr_ready = 0;
        repeat (8) step();
        chk("pre_rst_full", instr_valid, 1);
        chk("pre_rst_no_req", imem_req_valid, 0);
        rst = 1;
        step();
        chk_reset_outputs("mid_rst");
        rst = 0;
        chk("mid_rst_boot_no_req", imem_req_valid, 0);
        step();
        chk("mid_rst_first_req", imem_req_valid, 1);
        chk("mid_rst_first_addr", imem_addr, 32'h100);
        instr_ready = 1;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
